// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - byte-in / word-out handshake bundle for the SHA-256 padder
interface sha256_msg_padder_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [3:0]  w_idx;
    logic        w_first;
    logic        w_final;
    logic        busy;

    // master: byte source and word sink (host side); slave: the padder itself
    modport master (
        output in_byte, in_valid, in_last, w_ready,
        input  in_ready, w_data, w_valid, w_idx, w_first, w_final, busy
    );
    modport slave (
        input  in_byte, in_valid, in_last, w_ready,
        output in_ready, w_data, w_valid, w_idx, w_first, w_final, busy
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - packs message bytes big-endian, appends SHA-256 padding, emits 16-word blocks
module sha256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sha256_msg_padder_if.slave bus
);
    typedef enum logic [1:0] {S_DATA, S_PAD80, S_ZERO, S_LEN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  pos_q, pos_d;
    logic [23:0] acc_q, acc_d;
    logic [31:0] w_data_q, w_data_d;
    logic        w_valid_q, w_valid_d;
    logic [3:0]  w_idx_q, w_idx_d;
    logic        w_first_q, w_first_d;
    logic        w_final_q, w_final_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic        adv;
    logic        take;
    logic        byte_en;
    logic [7:0]  byte_val;
    logic        word_load;
    logic        final_acc;
    logic [63:0] len_bits;
    logic [7:0]  len_byte;
    logic [5:0]  pos_inc;

    // the engine only stalls while a finished word is still waiting for the core
    assign adv      = !(w_valid_q && !bus.w_ready);
    assign take     = (state_q == S_DATA) && bus.in_valid && adv;
    assign pos_inc  = pos_q + 6'd1;
    assign len_bits = 64'(cnt_q) << 3;
    // length bytes go out MSB first at pos 56..63, so pos[2:0] selects byte 7-k
    assign len_byte = len_bits[{3'd7 - pos_q[2:0], 3'b000} +: 8];

    always_comb begin
        state_d  = state_q;
        byte_en  = 1'b0;
        byte_val = 8'h00;
        case (state_q)
            S_DATA: begin
                if (take) begin
                    byte_en  = 1'b1;
                    byte_val = bus.in_byte;
                    if (bus.in_last) state_d = S_PAD80;
                end
            end
            S_PAD80: begin
                if (adv) begin
                    byte_en  = 1'b1;
                    byte_val = 8'h80;
                    state_d  = (pos_inc == 6'd56) ? S_LEN : S_ZERO;
                end
            end
            S_ZERO: begin
                // when the 0x80 landed past byte 55 this keeps filling through the wrap into the next block
                if (adv) begin
                    byte_en  = 1'b1;
                    byte_val = 8'h00;
                    if (pos_inc == 6'd56) state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (adv) begin
                    byte_en  = 1'b1;
                    byte_val = len_byte;
                    if (pos_q == 6'd63) state_d = S_DATA;
                end
            end
            default: state_d = S_DATA;
        endcase
    end

    assign word_load = byte_en && (pos_q[1:0] == 2'd3);
    assign final_acc = w_valid_q && bus.w_ready && w_final_q;

    always_comb begin
        pos_d     = pos_q;
        acc_d     = acc_q;
        w_data_d  = w_data_q;
        w_idx_d   = w_idx_q;
        w_first_d = w_first_q;
        w_final_d = w_final_q;
        w_valid_d = w_valid_q;
        if (w_valid_q && bus.w_ready) w_valid_d = 1'b0;
        if (byte_en) begin
            pos_d = pos_inc;
            acc_d = {acc_q[15:0], byte_val};
        end
        if (word_load) begin
            w_data_d  = {acc_q, byte_val};
            w_valid_d = 1'b1;
            w_idx_d   = pos_q[5:2];
            w_first_d = (pos_q[5:2] == 4'd0);
            w_final_d = (state_q == S_LEN) && (pos_q[5:2] == 4'd15);
        end
    end

    // a new message may start in the very cycle the previous final word is taken
    always_comb begin
        cnt_d  = cnt_q + LEN_W'(take);
        busy_d = busy_q;
        if (final_acc) begin
            cnt_d  = LEN_W'(take);
            busy_d = 1'b0;
        end
        if (take) busy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_DATA;
            pos_q     <= 6'd0;
            acc_q     <= 24'd0;
            w_data_q  <= 32'd0;
            w_valid_q <= 1'b0;
            w_idx_q   <= 4'd0;
            w_first_q <= 1'b0;
            w_final_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            acc_q     <= acc_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
            w_idx_q   <= w_idx_d;
            w_first_q <= w_first_d;
            w_final_q <= w_final_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.in_ready = rst_n && (state_q == S_DATA) && adv;
    assign bus.w_data   = w_data_q;
    assign bus.w_valid  = w_valid_q;
    assign bus.w_idx    = w_idx_q;
    assign bus.w_first  = w_first_q;
    assign bus.w_final  = w_final_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - directed bench for sha256_msg_padder with a word scoreboard
module tb_sha256_msg_padder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();
    sha256_msg_padder #(.LEN_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        first;
        logic        fin;
    } word_t;

    word_t       exp_q[$];
    logic [7:0]  msg[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          rand_bp = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_idx;
    int          cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // sampled on the falling edge, between the bench's input updates and the next active edge
    task automatic monitor_sample();
        word_t e;
        if (rst_n && bus.w_valid && held) begin
            n_cmp++;
            assert ({bus.w_data, bus.w_idx} === {held_data, held_idx}) else begin
                n_err++;
                $error("FAIL hold_stable observed=%h/%0d expected=%h/%0d", bus.w_data, bus.w_idx, held_data, held_idx);
            end
        end
        held = rst_n && bus.w_valid && !bus.w_ready;
        held_data = bus.w_data;
        held_idx  = bus.w_idx;
        if (rst_n && bus.w_valid && bus.w_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                assert (0) else begin
                    n_err++;
                    $error("FAIL unexpected_word observed=%h expected=none", bus.w_data);
                end
            end else begin
                e = exp_q.pop_front();
                assert ({bus.w_data, bus.w_idx, bus.w_first, bus.w_final} === e) else begin
                    n_err++;
                    $error("FAIL word observed=%h idx=%0d first=%b final=%b expected=%h idx=%0d first=%b final=%b",
                           bus.w_data, bus.w_idx, bus.w_first, bus.w_final, e.data, e.idx, e.first, e.fin);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_sample();
        @(posedge clk);
        #1;
        if (rand_bp) bus.w_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic set_ready(input logic v);
        bus.w_ready = v;
        #1;
    endtask

    // reference padding built straight from the message: 0x80, zeros to 56 mod 64, 64-bit bit length
    task automatic push_expected();
        logic [7:0]  p[$];
        logic [63:0] bl;
        word_t       e;
        int          nw;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) << 3;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        nw = p.size() / 4;
        for (int i = 0; i < nw; i++) begin
            e.data  = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            e.idx   = 4'(i % 16);
            e.first = (i % 16 == 0);
            e.fin   = (i == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_range(input int from, input int to_excl, input bit last_at_end);
        for (int i = from; i < to_excl; i++) begin
            bit acc;
            int t;
            bus.in_byte  = msg[i];
            bus.in_valid = 1'b1;
            bus.in_last  = last_at_end && (i == to_excl - 1);
            #1;
            acc = 1'b0;
            t = 0;
            while (!acc && t < 1000) begin
                acc = bus.in_ready;
                tick();
                t++;
            end
            if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while ((bus.busy !== 1'b0 || exp_q.size() != 0 || bus.w_valid !== 1'b0) && cycles < 3000) begin
            tick();
            cycles++;
        end
        if (cycles >= 3000) chk("done_timeout", 64'(cycles), 64'd0);
    endtask

    task automatic load_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    initial begin
        int lens[3];
        word_t e;
        lens = '{55, 56, 64};
        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.w_ready  = 1'b1;

        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_w_valid",  64'(bus.w_valid),  64'd0);
        chk("rst_w_data",   64'(bus.w_data),   64'd0);
        chk("rst_w_idx",    64'(bus.w_idx),    64'd0);
        chk("rst_w_first",  64'(bus.w_first),  64'd0);
        chk("rst_w_final",  64'(bus.w_final),  64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // "abc": 0x80 follows the last byte at once, final word handshakes 62 cycles after it
        load_abc();
        push_expected();
        send_range(0, 3, 1'b1);
        wait_done(cyc);
        chk("abc_latency", 64'(cyc), 64'd62);
        chk("abc_busy_end", 64'(bus.busy), 64'd0);

        foreach (lens[j]) begin
            msg.delete();
            for (int i = 0; i < lens[j]; i++) msg.push_back(8'h00);
            push_expected();
            send_range(0, lens[j], 1'b1);
            wait_done(cyc);
            chk("zeros_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        // hold the first padded word for five cycles
        set_ready(1'b0);
        load_abc();
        push_expected();
        send_range(0, 3, 1'b1);
        cyc = 0;
        while (bus.w_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_word_seen", 64'(bus.w_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_w_data",   64'(bus.w_data),   64'h61626380);
            chk("bp_w_idx",    64'(bus.w_idx),    64'd0);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        set_ready(1'b1);
        wait_done(cyc);

        // stall with a data byte waiting: in_ready must drop while the word is held
        msg.delete();
        for (int i = 0; i < 8; i++) msg.push_back(8'(8'h61 + i));
        push_expected();
        set_ready(1'b0);
        send_range(0, 4, 1'b0);
        bus.in_byte  = msg[4];
        bus.in_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_w_data",   64'(bus.w_data),   64'h61626364);
            tick();
        end
        set_ready(1'b1);
        send_range(4, 8, 1'b1);
        wait_done(cyc);

        rand_bp = 1'b1;
        for (int n = 119; n <= 120; n++) begin
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            push_expected();
            send_range(0, n, 1'b1);
            wait_done(cyc);
        end
        rand_bp = 1'b0;
        set_ready(1'b1);

        // reset after 10 bytes: only the two words already completed may appear
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'(8'hA0 + i));
        e.data = {msg[0], msg[1], msg[2], msg[3]}; e.idx = 4'd0; e.first = 1'b1; e.fin = 1'b0;
        exp_q.push_back(e);
        e.data = {msg[4], msg[5], msg[6], msg[7]}; e.idx = 4'd1; e.first = 1'b0; e.fin = 1'b0;
        exp_q.push_back(e);
        send_range(0, 10, 1'b0);
        tick();
        chk("pre_rst_queue_empty", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        chk("mid_rst_w_valid", 64'(bus.w_valid), 64'd0);
        chk("mid_rst_busy",    64'(bus.busy),    64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_w_valid", 64'(bus.w_valid), 64'd0);
        load_abc();
        push_expected();
        send_range(0, 3, 1'b1);
        wait_done(cyc);
        chk("post_rst_abc_latency", 64'(cyc), 64'd62);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
